noc_msg_rr_arbiter: RTL and testbench
=====================================

// Module: noc_msg_rr_arbiter
// PURPOSE
//   Shares one NoC output link between NUM_SRCS message sources. A source wins the link
//   in round-robin order and holds it for its whole message: header flit plus msg_len
//   body flits. msg_len is taken from the base_noc_hdr_flit at the MSB end of the header.
//   Sits between per-tile engines (e.g. TCP/UDP/IP TX) and a shared router port, so
//   messages are never interleaved.
// PARAMETERS
//   NUM_SRCS     4                 number of requesters, >=2
//   DATA_W       `NOC_DATA_WIDTH   flit width
//   LEN_W        `MSG_LENGTH_WIDTH width of the msg_len header field
//   LEN_LSB      DATA_W-`MSG_DST_CHIPID_WIDTH-`MSG_DST_X_WIDTH-`MSG_DST_Y_WIDTH-`MSG_DST_FBITS_WIDTH-LEN_W
//                                  bit position of msg_len inside a header flit
// PORTS
//   clk            in   1                  clock
//   rst            in   1                  synchronous active-high reset
//   src_noc_val    in   NUM_SRCS           per-source flit valid
//   src_noc_data   in   NUM_SRCS*DATA_W    per-source flit; source i uses [i*DATA_W +: DATA_W]
//   src_noc_rdy    out  NUM_SRCS           per-source flit accepted
//   dst_noc_val    out  1                  output flit valid
//   dst_noc_data   out  DATA_W             output flit
//   dst_noc_rdy    in   1                  downstream ready
//   arb_busy       out  1                  1 while a message body is in progress (state BODY)
//   arb_grant      out  $clog2(NUM_SRCS)   source currently owning / being offered the link
// BEHAVIOUR
//   - Handshake: a flit transfers when val&rdy. Ready/valid; valid must not depend on rdy.
//     Pass-through datapath with zero latency: dst_noc_data = src_noc_data[arb_grant],
//     dst_noc_val = src_noc_val[arb_grant] (gated by state),
//     src_noc_rdy[i] = dst_noc_rdy & (i==arb_grant) & active.
//     No flit is buffered.
//   - State: IDLE, BODY. Registers: state, rr_ptr (next-priority source), owner, flits_left[LEN_W].
//   - IDLE: arb_grant = first i with src_noc_val[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_SRCS.
//     If none is valid, arb_grant = rr_ptr and dst_noc_val = 0.
//     The winning flit is a header.
//     - On header handshake with msg_len==0: stay IDLE, rr_ptr <= grant+1 (mod NUM_SRCS).
//     - With msg_len!=0: owner <= grant, flits_left <= msg_len, go to BODY.
//     - With no handshake (dst_noc_rdy=0): no state change. Grant may move next cycle if
//       valids change; sources must hold val once asserted.
//   - BODY: arb_grant = owner; only the owner sees rdy. A gap on the owner's val stalls the
//     link, with no re-arbitration.
//     - Each handshake: flits_left <= flits_left-1.
//     - Handshake with flits_left==1: go to IDLE, rr_ptr <= owner+1 (mod NUM_SRCS).
//       The next message may start the following cycle, so back-to-back messages have
//       no dead cycle.
//   - Width rules: flits_left is LEN_W bits unsigned; msg_len max 2^LEN_W-1 body flits.
//     rr_ptr wraps NUM_SRCS-1 -> 0, including non-power-of-2 NUM_SRCS.
//   - Reset values (also when rst asserts mid-message): state=IDLE, rr_ptr=0, owner=0,
//     flits_left=0. While rst=1: dst_noc_val=0, src_noc_rdy=0, arb_busy=0, arb_grant=0.
//     A message cut by reset is abandoned; no partial-message recovery.
//   - Fairness: a source with val held continuously is granted within NUM_SRCS-1 messages.
//     Body flits of one message are never interleaved with another source's flits.
// TESTING
//   1. Single source 2, header msg_len=3, dst_rdy=1 -> 4 flits in order on cycles t..t+3;
//      arb_busy=1 for t+1..t+3; rr_ptr=3 after.
//   2. All 4 valid, each sends msg_len=1, rdy=1 -> output order src0,0,1,1,2,2,3,3,
//      then src0 again; no gaps.
//   3. Src1 in BODY (flits_left=2), src0 raises val -> src0 rdy stays 0 until src1's
//      last flit, then src0 header next cycle.
//   4. dst_noc_rdy toggles 1,0,1,0 during 5-flit message -> data held stable while rdy=0;
//      exactly 5 transfers; flits_left decrements only on handshake.
//   5. msg_len=0 headers from src3 then src0 -> two 1-flit messages, state never leaves
//      IDLE, rr_ptr 3 -> 0 -> 1 (wrap).
//   6. rst pulsed at flits_left=2 -> next cycle dst_noc_val=0, state IDLE, rr_ptr=0;
//      new src2 header accepted after rst deasserts.

Source files
------------

// File: rtl/noc_msg_rr_arbiter.sv
// noc_msg_rr_arbiter
//   Shares one NoC output link between NUM_SRCS message sources. Sources win the
//   link in round-robin order and keep it for a whole message (header flit plus
//   msg_len body flits), so messages from different sources never interleave.
//   The datapath is a zero-latency mux; no flit is ever buffered here.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   src_noc_val    per-source flit valid            [NUM_SRCS]
//   src_noc_data   per-source flit, source i at [i*DATA_W +: DATA_W]
//   src_noc_rdy    per-source flit accepted         [NUM_SRCS]
//   dst_noc_val    output flit valid
//   dst_noc_data   output flit                      [DATA_W]
//   dst_noc_rdy    downstream ready
//   arb_busy       high while a message body is in progress
//   arb_grant      source owning / being offered the link

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif
`ifndef MSG_DST_CHIPID_WIDTH
`define MSG_DST_CHIPID_WIDTH 14
`endif
`ifndef MSG_DST_X_WIDTH
`define MSG_DST_X_WIDTH 8
`endif
`ifndef MSG_DST_Y_WIDTH
`define MSG_DST_Y_WIDTH 8
`endif
`ifndef MSG_DST_FBITS_WIDTH
`define MSG_DST_FBITS_WIDTH 4
`endif

module noc_msg_rr_arbiter #(
  parameter int NUM_SRCS = 4,
  parameter int DATA_W   = `NOC_DATA_WIDTH,
  parameter int LEN_W    = `MSG_LENGTH_WIDTH,
  parameter int LEN_LSB  = DATA_W - `MSG_DST_CHIPID_WIDTH - `MSG_DST_X_WIDTH
                           - `MSG_DST_Y_WIDTH - `MSG_DST_FBITS_WIDTH - LEN_W,
  localparam int GW      = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRCS-1:0]        src_noc_val,
  input  logic [NUM_SRCS*DATA_W-1:0] src_noc_data,
  output logic [NUM_SRCS-1:0]        src_noc_rdy,
  output logic                       dst_noc_val,
  output logic [DATA_W-1:0]          dst_noc_data,
  input  logic                       dst_noc_rdy,
  output logic                       arb_busy,
  output logic [GW-1:0]              arb_grant
);

  typedef enum logic {IDLE, BODY} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [GW-1:0]     owner, owner_nxt;
  logic [LEN_W-1:0]  flits_left, flits_left_nxt;
  logic [GW-1:0]     search_idx;
  logic [GW-1:0]     grant;
  logic [LEN_W-1:0]  hdr_len;
  logic              handshake;

  // Modulo-NUM_SRCS increment; explicit compare so non-power-of-2 counts wrap.
  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] x);
    if (x == GW'(NUM_SRCS - 1)) return '0;
    return x + GW'(1);
  endfunction

  // Round-robin search starting at rr_ptr; falls back to rr_ptr when nobody
  // is valid, which keeps dst_noc_val low because that source is not valid.
  always_comb begin
    int  c;
    logic found;
    search_idx = rr_ptr;
    found      = 1'b0;
    c          = 0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_SRCS) c = c - NUM_SRCS;
      if (!found && src_noc_val[c]) begin
        found      = 1'b1;
        search_idx = GW'(c);
      end
    end
  end

  // During a body the owner is locked in; reset forces everything quiet.
  always_comb begin
    if (rst)                grant = '0;
    else if (state == BODY) grant = owner;
    else                    grant = search_idx;
  end

  assign arb_grant    = grant;
  assign dst_noc_data = src_noc_data[grant*DATA_W +: DATA_W];
  assign dst_noc_val  = !rst && src_noc_val[grant];
  assign arb_busy     = !rst && (state == BODY);
  assign handshake    = dst_noc_val && dst_noc_rdy;
  assign hdr_len      = dst_noc_data[LEN_LSB +: LEN_W];

  for (genvar i = 0; i < NUM_SRCS; i++) begin : g_rdy
    assign src_noc_rdy[i] = dst_noc_rdy && !rst && (grant == GW'(i));
  end

  // Next-state logic: a zero-length header is a complete message on its own,
  // so it advances the pointer without ever entering BODY.
  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    owner_nxt      = owner;
    flits_left_nxt = flits_left;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (hdr_len == '0) begin
            rr_ptr_nxt = wrap_inc(grant);
          end else begin
            owner_nxt      = grant;
            flits_left_nxt = hdr_len;
            state_nxt      = BODY;
          end
        end
      end
      BODY: begin
        if (handshake) begin
          flits_left_nxt = flits_left - LEN_W'(1);
          if (flits_left == LEN_W'(1)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(owner);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset abandons any message in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      flits_left <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner      <= owner_nxt;
      flits_left <= flits_left_nxt;
    end
  end

endmodule

// File: tb/tb_noc_msg_rr_arbiter.sv
// tb_noc_msg_rr_arbiter
//   Random traffic from four sources, each with a queue of whole messages,
//   compared every cycle against a message-level round-robin model.

module tb_noc_msg_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int LL = 22;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_noc_val;
  logic [N*DW-1:0] src_noc_data;
  logic [N-1:0]    src_noc_rdy;
  logic            dst_noc_val;
  logic [DW-1:0]   dst_noc_data;
  logic            dst_noc_rdy;
  logic            arb_busy;
  logic [1:0]      arb_grant;

  noc_msg_rr_arbiter #(
    .NUM_SRCS(N), .DATA_W(DW), .LEN_W(LW), .LEN_LSB(LL)
  ) dut (
    .clk(clk), .rst(rst),
    .src_noc_val(src_noc_val), .src_noc_data(src_noc_data), .src_noc_rdy(src_noc_rdy),
    .dst_noc_val(dst_noc_val), .dst_noc_data(dst_noc_data), .dst_noc_rdy(dst_noc_rdy),
    .arb_busy(arb_busy), .arb_grant(arb_grant)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Pending flits per source, front is the next flit to offer.
  logic [DW-1:0] q [N][$];
  logic [N-1:0]  held;

  // Message-level model: who holds the link and how many body flits remain.
  int m_rr;
  int m_owner;
  int m_left;
  bit m_body;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushMessage(input int s);
    logic [DW-1:0] hdr;
    int len;
    len = ($urandom_range(0, 49) == 0) ? 255 : $urandom_range(0, 4);
    hdr = {$urandom, $urandom};
    hdr[LL +: LW] = LW'(len);
    q[s].push_back(hdr);
    for (int j = 0; j < len; j++) q[s].push_back({$urandom, $urandom});
  endtask

  task automatic applyStimulus(input bit do_rst);
    rst         = do_rst;
    dst_noc_rdy = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < N; i++) begin
      if (!do_rst && q[i].size() == 0 && $urandom_range(0, 2) == 0) pushMessage(i);
      if (do_rst) src_noc_val[i] = 1'b0;
      else        src_noc_val[i] = held[i] || (q[i].size() != 0 && $urandom_range(0, 3) != 0);
      src_noc_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : {$urandom, $urandom};
    end
  endtask

  initial begin
    int  g;
    bit  ev;
    bit  r;
    bit  hs;
    logic [DW-1:0] flit;

    rst          = 1'b1;
    src_noc_val  = '0;
    src_noc_data = '0;
    dst_noc_rdy  = 1'b0;
    held         = '0;
    m_rr = 0; m_owner = 0; m_left = 0; m_body = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      r = (cyc < 3) || ($urandom_range(0, 249) == 0);
      applyStimulus(r);
      #1;

      if (r) begin
        g  = 0;
        ev = 0;
      end else if (m_body) begin
        g  = m_owner;
        ev = src_noc_val[g];
      end else begin
        g = m_rr;
        for (int k = 0; k < N; k++) begin
          if (src_noc_val[(m_rr + k) % N]) begin
            g = (m_rr + k) % N;
            break;
          end
        end
        ev = src_noc_val[g];
      end

      checkOutput("grant", 64'(arb_grant), 64'(g));
      checkOutput("dst_val", 64'(dst_noc_val), 64'(ev));
      checkOutput("src_rdy", 64'(src_noc_rdy), (!r && dst_noc_rdy) ? 64'(1 << g) : 64'(0));
      checkOutput("busy", 64'(arb_busy), 64'(!r && m_body));
      if (ev) checkOutput("data", dst_noc_data, q[g][0]);

      @(posedge clk);
      if (r) begin
        for (int i = 0; i < N; i++) q[i].delete();
        held = '0;
        m_rr = 0; m_owner = 0; m_left = 0; m_body = 0;
      end else begin
        hs = ev && dst_noc_rdy;
        for (int i = 0; i < N; i++) held[i] = src_noc_val[i] && !(hs && g == i);
        if (hs) begin
          flit = q[g].pop_front();
          if (!m_body) begin
            if (flit[LL +: LW] == 0) begin
              m_rr = (g + 1) % N;
            end else begin
              m_body  = 1;
              m_owner = g;
              m_left  = int'(flit[LL +: LW]);
            end
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_body = 0;
              m_rr   = (m_owner + 1) % N;
            end
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
